// File: rtl/sha_job_scheduler.sv
// ---------------------------------------------------------------------------
// sha_job_scheduler
//
// Purpose:
//   Hands padded SHA message blocks from a single AXI-Stream source to a pool
//   of hash engines. When a message arrives, the scheduler picks the first
//   free engine at or after a round-robin pointer. It pulses that engine's
//   start strobe for one cycle with the message sha_type. It then routes
//   every block of the message to that engine with zero latency until the
//   beat marked tlast is accepted. An engine stays busy until it pulses
//   eng_done.
//
// Handshake semantics (both stream sides):
//   A beat transfers on a rising edge of axi_aclk where tvalid and tready are
//   both 1. The source holds tdata/tlast/tuser stable while tvalid=1 and
//   tready=0. tready may depend combinationally on the downstream tready of
//   the granted engine, but never on tvalid.
//
// Ports:
//   axi_aclk       clock
//   reset          synchronous, active-high
//   s_axis_*       upstream block stream (tuser = sha_type, taken on 1st beat)
//   eng_en         one-cycle start pulse, one bit per engine
//   eng_sha_type   sha_type of the engine most recently started
//   m_axis_tdata   block bus shared by all engines
//   m_axis_tvalid  per-engine valid (only the granted engine's bit can be 1)
//   m_axis_tready  per-engine ready
//   m_axis_tlast   copy of s_axis_tlast
//   eng_done       one-cycle pulse per engine: message finished
//   eng_busy       engine owns a message
//   cur_engine     engine currently granted
//   job_count      messages fully dispatched (wraps at 16 bits)
//   fsm_state      debug view of the scheduler state
// ---------------------------------------------------------------------------
module sha_job_scheduler #(
   parameter int NUM_ENGINES       = 4,
   parameter int S_AXIS_DATA_WIDTH = 512,
   parameter int ENG_IDX_WIDTH     = 2
) (
   input  logic                         axi_aclk,
   input  logic                         reset,
   input  logic [S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [1:0]                   s_axis_tuser,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic                         s_axis_tlast,
   output logic [NUM_ENGINES-1:0]       eng_en,
   output logic [1:0]                   eng_sha_type,
   output logic [S_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [NUM_ENGINES-1:0]       m_axis_tvalid,
   input  logic [NUM_ENGINES-1:0]       m_axis_tready,
   output logic                         m_axis_tlast,
   input  logic [NUM_ENGINES-1:0]       eng_done,
   output logic [NUM_ENGINES-1:0]       eng_busy,
   output logic [ENG_IDX_WIDTH-1:0]     cur_engine,
   output logic [15:0]                  job_count,
   output logic [1:0]                   fsm_state
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_ROUTE = 2'd2;

   logic [1:0]               state_q;
   logic [ENG_IDX_WIDTH-1:0] rr_ptr_q;
   logic [ENG_IDX_WIDTH-1:0] cur_q;
   logic [1:0]               type_q;
   logic [NUM_ENGINES-1:0]   busy_q;
   logic [NUM_ENGINES-1:0]   busy_d;
   logic [15:0]              job_cnt_q;
   logic [15:0]              job_cnt_d;

   logic                     sel_found;
   logic [ENG_IDX_WIDTH-1:0] sel_idx;
   logic [ENG_IDX_WIDTH-1:0] cand_idx;
   int                       cand;

   logic                     last_hs;
   logic [ENG_IDX_WIDTH-1:0] rr_next;

   // First free engine scanning upward from rr_ptr, wrapping at NUM_ENGINES
   // (which need not be a power of two).
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NUM_ENGINES) cand = cand - NUM_ENGINES;
         cand_idx = ENG_IDX_WIDTH'(cand);
         if (!sel_found && !busy_q[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   // Zero-latency routing of the upstream stream to the granted engine.
   always_comb begin
      m_axis_tvalid = '0;
      s_axis_tready = 1'b0;
      eng_en        = '0;
      if (state_q == ST_ROUTE) begin
         m_axis_tvalid[cur_q] = s_axis_tvalid;
         s_axis_tready        = m_axis_tready[cur_q];
      end
      if (state_q == ST_GRANT) eng_en[cur_q] = 1'b1;
   end

   assign m_axis_tdata = s_axis_tdata;
   assign m_axis_tlast = s_axis_tlast;

   // s_axis_tready is only ever 1 in ROUTE, so this is the end of a message.
   assign last_hs = s_axis_tvalid & s_axis_tready & s_axis_tlast;

   assign rr_next = (cur_q == ENG_IDX_WIDTH'(NUM_ENGINES - 1)) ? '0 : cur_q + 1'b1;

   // Done pulses clear busy bits (idle engines are unaffected by the AND),
   // and the grant set is applied last so it wins a same-cycle done.
   always_comb begin
      busy_d = busy_q & ~eng_done;
      if (state_q == ST_GRANT) busy_d[cur_q] = 1'b1;
   end

   assign job_cnt_d = last_hs ? job_cnt_q + 16'd1 : job_cnt_q;

   always_ff @(posedge axi_aclk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         cur_q     <= '0;
         type_q    <= 2'd0;
         busy_q    <= '0;
         job_cnt_q <= 16'd0;
      end else begin
         busy_q    <= busy_d;
         job_cnt_q <= job_cnt_d;
         case (state_q)
            ST_IDLE: begin
               if (s_axis_tvalid && sel_found) begin
                  cur_q   <= sel_idx;
                  type_q  <= s_axis_tuser;
                  state_q <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               state_q <= ST_ROUTE;
            end
            ST_ROUTE: begin
               if (last_hs) begin
                  state_q  <= ST_IDLE;
                  rr_ptr_q <= rr_next;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign eng_sha_type = type_q;
   assign eng_busy     = busy_q;
   assign cur_engine   = cur_q;
   assign job_count    = job_cnt_q;
   assign fsm_state    = state_q;

endmodule
